// File: rtl/menu_pkg.sv
// Shared constants for the menu/alarm controller: item indices, label
// rectangles of the right-column menu and the alarm state encoding.
package menu_pkg;

    localparam int MENU_ITEMS = 7;

    localparam logic [2:0] ITEM_RESET   = 3'd0;
    localparam logic [2:0] ITEM_SALIR   = 3'd1;
    localparam logic [2:0] ITEM_FORMATO = 3'd2;
    localparam logic [2:0] ITEM_DETENER = 3'd3;
    localparam logic [2:0] ITEM_PROGF   = 3'd4;
    localparam logic [2:0] ITEM_PROGH   = 3'd5;
    localparam logic [2:0] ITEM_PROGT   = 3'd6;

    // All labels share the same left edge.
    localparam logic [9:0] MENU_X0 = 10'd370;

    // Per-item rectangle origin row, width and height, indexed by item.
    localparam logic [9:0] ITEM_Y0 [MENU_ITEMS] =
        '{10'd165, 10'd205, 10'd245, 10'd285, 10'd325, 10'd365, 10'd405};
    localparam logic [9:0] ITEM_W  [MENU_ITEMS] =
        '{10'd101, 10'd94,  10'd120, 10'd158, 10'd155, 10'd155, 10'd152};
    localparam logic [9:0] ITEM_H  [MENU_ITEMS] =
        '{10'd25,  10'd24,  10'd24,  10'd22,  10'd33,  10'd31,  10'd32};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RINGING  = 2'd1,
        SILENCED = 2'd2
    } alarm_state_t;

endpackage

// File: rtl/rect_hit.sv
// Combinational point-in-rectangle test: inclusive of the origin,
// exclusive of origin+size. Sums are widened so they cannot wrap.
module rect_hit (
    input  logic [9:0] px,
    input  logic [9:0] py,
    input  logic [9:0] x0,
    input  logic [9:0] y0,
    input  logic [9:0] w,
    input  logic [9:0] h,
    output logic       hit
);

    logic [10:0] x_end;
    logic [10:0] y_end;

    assign x_end = {1'b0, x0} + {1'b0, w};
    assign y_end = {1'b0, y0} + {1'b0, h};

    // Bounds compare on both axes.
    always_comb begin
        hit = ({1'b0, px} >= {1'b0, x0}) && ({1'b0, px} < x_end) &&
              ({1'b0, py} >= {1'b0, y0}) && ({1'b0, py} < y_end);
    end

endmodule

// File: rtl/menu_alarm_ctrl.sv
// Menu cursor / select sequencing, selected-label highlight and the alarm
// ring-image state machine (blink, timeout, silencing).
module menu_alarm_ctrl
    import menu_pkg::*;
#(
    parameter int BLINK_FRAMES        = 15,
    parameter int RING_TIMEOUT_FRAMES = 3600,
    parameter int N_ITEMS             = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_frame,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       video_on,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_sel,
    input  logic       alarm_match,
    input  logic       alarm_stop,
    output logic [2:0] cursor,
    output logic       sel_cmd,
    output logic [2:0] sel_item,
    output logic       highlight_on,
    output logic       ring_visible,
    output logic       ringing
);

    localparam int         BLINK_W   = $clog2(BLINK_FRAMES);
    localparam int         RING_W    = $clog2(RING_TIMEOUT_FRAMES);
    localparam logic [2:0] LAST_ITEM = 3'(N_ITEMS - 1);

    alarm_state_t      state_reg, state_next;
    logic              phase_reg, phase_next;
    logic [BLINK_W-1:0] blink_cnt_reg, blink_cnt_next;
    logic [RING_W-1:0]  ring_cnt_reg, ring_cnt_next;
    logic [2:0]        cursor_reg, cursor_next;
    logic              sel_cmd_reg, sel_cmd_next;
    logic [2:0]        sel_item_reg, sel_item_next;
    logic              highlight_reg, highlight_next;

    logic up_prev_reg, down_prev_reg, sel_prev_reg, match_prev_reg;
    logic up_press, down_press, sel_press, match_rise;

    logic [9:0] rect_y0, rect_w, rect_h;
    logic       hit;

    assign up_press   = btn_up & ~up_prev_reg;
    assign down_press = btn_down & ~down_prev_reg;
    assign sel_press  = btn_sel & ~sel_prev_reg;
    assign match_rise = alarm_match & ~match_prev_reg;

    // Pick the selected item's rectangle; out-of-range cursor falls back to item 0.
    always_comb begin
        rect_y0 = ITEM_Y0[0];
        rect_w  = ITEM_W[0];
        rect_h  = ITEM_H[0];
        if (cursor_reg <= LAST_ITEM) begin
            rect_y0 = ITEM_Y0[cursor_reg];
            rect_w  = ITEM_W[cursor_reg];
            rect_h  = ITEM_H[cursor_reg];
        end
    end

    rect_hit u_rect_hit (
        .px  (pixel_x),
        .py  (pixel_y),
        .x0  (MENU_X0),
        .y0  (rect_y0),
        .w   (rect_w),
        .h   (rect_h),
        .hit (hit)
    );

    // Register all state. The alarm_match history resets high so a level
    // already high when reset releases is not mistaken for a new alarm.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            phase_reg      <= 1'b0;
            blink_cnt_reg  <= '0;
            ring_cnt_reg   <= '0;
            cursor_reg     <= ITEM_RESET;
            sel_cmd_reg    <= 1'b0;
            sel_item_reg   <= ITEM_RESET;
            highlight_reg  <= 1'b0;
            up_prev_reg    <= 1'b0;
            down_prev_reg  <= 1'b0;
            sel_prev_reg   <= 1'b0;
            match_prev_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            phase_reg      <= phase_next;
            blink_cnt_reg  <= blink_cnt_next;
            ring_cnt_reg   <= ring_cnt_next;
            cursor_reg     <= cursor_next;
            sel_cmd_reg    <= sel_cmd_next;
            sel_item_reg   <= sel_item_next;
            highlight_reg  <= highlight_next;
            up_prev_reg    <= btn_up;
            down_prev_reg  <= btn_down;
            sel_prev_reg   <= btn_sel;
            match_prev_reg <= alarm_match;
        end
    end

    // Next-state: alarm FSM, cursor moves, select pulse and highlight.
    always_comb begin
        state_next     = state_reg;
        phase_next     = phase_reg;
        blink_cnt_next = blink_cnt_reg;
        ring_cnt_next  = ring_cnt_reg;
        cursor_next    = cursor_reg;
        sel_cmd_next   = 1'b0;
        sel_item_next  = sel_item_reg;
        highlight_next = video_on & hit;

        case (state_reg)
            IDLE: begin
                if (match_rise) begin
                    state_next     = RINGING;
                    phase_next     = 1'b1;
                    blink_cnt_next = '0;
                    ring_cnt_next  = '0;
                end
            end
            RINGING: begin
                if (tick_frame) begin
                    if (blink_cnt_reg == BLINK_W'(BLINK_FRAMES - 1)) begin
                        blink_cnt_next = '0;
                        phase_next     = ~phase_reg;
                    end else begin
                        blink_cnt_next = blink_cnt_reg + 1'b1;
                    end
                    ring_cnt_next = ring_cnt_reg + 1'b1;
                end
                // Timeout and stop requests converge on the same state.
                if ((tick_frame && (ring_cnt_reg == RING_W'(RING_TIMEOUT_FRAMES - 1))) ||
                    alarm_stop || sel_press) begin
                    state_next = SILENCED;
                end
            end
            SILENCED: begin
                if (!alarm_match) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // While ringing the buttons belong to the alarm, not the menu.
        if (state_reg != RINGING) begin
            if (sel_press) begin
                sel_cmd_next  = 1'b1;
                sel_item_next = cursor_reg;
            end
            if (up_press && !down_press) begin
                cursor_next = (cursor_reg == 3'd0) ? LAST_ITEM : cursor_reg - 3'd1;
            end else if (down_press && !up_press) begin
                cursor_next = (cursor_reg >= LAST_ITEM) ? 3'd0 : cursor_reg + 3'd1;
            end
        end
    end

    assign cursor       = cursor_reg;
    assign sel_cmd      = sel_cmd_reg;
    assign sel_item     = sel_item_reg;
    assign highlight_on = highlight_reg;
    assign ringing      = (state_reg == RINGING);
    assign ring_visible = (state_reg == RINGING) & phase_reg;

endmodule

// File: tb/tb_menu_alarm_ctrl.sv
// Directed bench for menu_alarm_ctrl: table-driven cursor/select and
// highlight vectors plus hand-written alarm sequences. A second instance
// with a short timeout exercises automatic silencing.
module tb_menu_alarm_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_frame;
    logic [9:0] pixel_x, pixel_y;
    logic       video_on;
    logic       btn_up, btn_down, btn_sel;
    logic       alarm_match, alarm_stop;

    logic [2:0] cursor, sel_item;
    logic       sel_cmd, highlight_on, ring_visible, ringing;
    logic [2:0] cursor_t, sel_item_t;
    logic       sel_cmd_t, highlight_on_t, ring_visible_t, ringing_t;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    menu_alarm_ctrl dut (
        .clk(clk), .reset(reset), .tick_frame(tick_frame),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
        .alarm_match(alarm_match), .alarm_stop(alarm_stop),
        .cursor(cursor), .sel_cmd(sel_cmd), .sel_item(sel_item),
        .highlight_on(highlight_on), .ring_visible(ring_visible), .ringing(ringing)
    );

    menu_alarm_ctrl #(.RING_TIMEOUT_FRAMES(10)) dut_to (
        .clk(clk), .reset(reset), .tick_frame(tick_frame),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
        .alarm_match(alarm_match), .alarm_stop(alarm_stop),
        .cursor(cursor_t), .sel_cmd(sel_cmd_t), .sel_item(sel_item_t),
        .highlight_on(highlight_on_t), .ring_visible(ring_visible_t), .ringing(ringing_t)
    );

    typedef struct {
        logic       up, down, sel;
        logic [2:0] exp_cursor;
        logic       exp_cmd;
        logic [2:0] exp_item;
    } btn_vec_t;

    typedef struct {
        logic [9:0] x, y;
        logic       vo;
        logic       exp_hl;
    } hl_vec_t;

    btn_vec_t bv [28];
    hl_vec_t  hv [7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic u, input logic d, input logic s);
        btn_up = u; btn_down = d; btn_sel = s;
        step();
        btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0;
        step();
    endtask

    initial begin
        int pulses;
        logic [2:0] item_seen;

        // Cursor/select table: one cycle per row, cursor starts at 0.
        bv[0]  = '{1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 3'd0};
        bv[1]  = '{1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 3'd0};
        bv[2]  = '{1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 3'd0};
        bv[3]  = '{1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 3'd0};
        bv[4]  = '{1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 3'd0};
        bv[5]  = '{1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 3'd0};
        bv[6]  = '{1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 3'd0};
        bv[7]  = '{1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 3'd0};
        bv[8]  = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 3'd0};
        bv[9]  = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 3'd0}; // held: no second move
        bv[10] = '{1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 3'd0};
        bv[11] = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0};
        bv[12] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0};
        bv[13] = '{1'b1, 1'b0, 1'b0, 3'd6, 1'b0, 3'd0}; // wrap 0 -> 6
        bv[14] = '{1'b0, 1'b0, 1'b0, 3'd6, 1'b0, 3'd0};
        bv[15] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0}; // wrap 6 -> 0
        bv[16] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0};
        bv[17] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0}; // up+down: no change
        bv[18] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0};
        bv[19] = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 3'd0};
        bv[20] = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd0}; // held sel: one pulse
        bv[21] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0};
        bv[22] = '{1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 3'd0}; // sel+down: pre-move item
        bv[23] = '{1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 3'd0};
        bv[24] = '{1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 3'd0};
        bv[25] = '{1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 3'd0};
        bv[26] = '{1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 3'd2}; // sel+up: pre-move item
        bv[27] = '{1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 3'd2};

        // Detener rectangle: x 370..527, y 285..306.
        hv[0] = '{10'd370, 10'd285, 1'b1, 1'b1};
        hv[1] = '{10'd527, 10'd306, 1'b1, 1'b1};
        hv[2] = '{10'd528, 10'd285, 1'b1, 1'b0};
        hv[3] = '{10'd370, 10'd307, 1'b1, 1'b0};
        hv[4] = '{10'd369, 10'd285, 1'b1, 1'b0};
        hv[5] = '{10'd370, 10'd284, 1'b1, 1'b0};
        hv[6] = '{10'd400, 10'd290, 1'b0, 1'b0};

        reset = 1'b1; tick_frame = 1'b0; pixel_x = '0; pixel_y = '0; video_on = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0;
        alarm_match = 1'b0; alarm_stop = 1'b0;
        repeat (3) step();
        chk("rst_cursor", cursor, 0);
        chk("rst_sel_cmd", sel_cmd, 0);
        chk("rst_sel_item", sel_item, 0);
        chk("rst_highlight", highlight_on, 0);
        chk("rst_ring_visible", ring_visible, 0);
        chk("rst_ringing", ringing, 0);
        chk("rst_to_all", {cursor_t, sel_cmd_t, sel_item_t, highlight_on_t,
                           ring_visible_t, ringing_t}, 0);
        reset = 1'b0;
        step();

        // Cursor and select table.
        for (int i = 0; i < 28; i++) begin
            btn_up = bv[i].up; btn_down = bv[i].down; btn_sel = bv[i].sel;
            step();
            $display("btn vec %0d up=%0b down=%0b sel=%0b -> cursor=%0d sel_cmd=%0b sel_item=%0d",
                     i, bv[i].up, bv[i].down, bv[i].sel, cursor, sel_cmd, sel_item);
            chk($sformatf("btn%0d_cursor", i), cursor, bv[i].exp_cursor);
            chk($sformatf("btn%0d_sel_cmd", i), sel_cmd, bv[i].exp_cmd);
            chk($sformatf("btn%0d_sel_item", i), sel_item, bv[i].exp_item);
        end
        btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0;
        step();

        // Highlight on Detener (cursor 1 -> 3).
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        chk("hl_cursor3", cursor, 3);
        for (int i = 0; i < 7; i++) begin
            pixel_x = hv[i].x; pixel_y = hv[i].y; video_on = hv[i].vo;
            step();
            $display("hl vec %0d x=%0d y=%0d vo=%0b -> highlight_on=%0b",
                     i, hv[i].x, hv[i].y, hv[i].vo, highlight_on);
            chk($sformatf("hl%0d", i), highlight_on, hv[i].exp_hl);
        end
        // One-clock latency: new pixel not reflected before the next edge.
        pixel_x = 10'd400; pixel_y = 10'd290; video_on = 1'b1;
        #1;
        chk("hl_latency_before", highlight_on, 0);
        step();
        chk("hl_latency_after", highlight_on, 1);

        // Move to ProgH (x 370..524, y 365..395) and hold sel for 20 cycles.
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        chk("cursor5", cursor, 5);
        pixel_x = 10'd524; pixel_y = 10'd395;
        step();
        chk("hl_progh_in", highlight_on, 1);
        pixel_x = 10'd525;
        step();
        chk("hl_progh_out", highlight_on, 0);
        pulses = 0; item_seen = 3'd0;
        btn_sel = 1'b1;
        for (int i = 0; i < 22; i++) begin
            if (i == 20) btn_sel = 1'b0;
            step();
            if (sel_cmd) begin
                pulses++;
                item_seen = sel_item;
            end
        end
        $display("sel hold: pulses=%0d item=%0d", pulses, item_seen);
        chk("sel_hold_pulses", pulses, 1);
        chk("sel_hold_item", item_seen, 5);

        // Alarm ring: 45 frames of blink; short-timeout instance silences after 10.
        alarm_match = 1'b1;
        step();
        chk("ring_enter", ringing, 1);
        for (int f = 0; f < 45; f++) begin
            $display("frame %0d ringing=%0b ring_visible=%0b ringing_to=%0b",
                     f, ringing, ring_visible, ringing_t);
            chk($sformatf("frame%0d_visible", f), ring_visible, ((f / 15) % 2 == 0) ? 1 : 0);
            chk($sformatf("frame%0d_ringing", f), ringing, 1);
            chk($sformatf("frame%0d_ringing_to", f), ringing_t, (f < 10) ? 1 : 0);
            tick_frame = 1'b1;
            step();
            tick_frame = 1'b0;
            step();
        end

        // Buttons during ringing: up ignored, sel silences without sel_cmd.
        press(1'b1, 1'b0, 1'b0);
        chk("ring_up_ignored", cursor, 5);
        chk("ring_still", ringing, 1);
        btn_sel = 1'b1;
        step();
        chk("silence_ringing", ringing, 0);
        chk("silence_no_cmd", sel_cmd, 0);
        chk("silence_cursor", cursor, 5);
        btn_sel = 1'b0;
        step();
        chk("silence_no_cmd_late", sel_cmd, 0);
        repeat (5) step();
        chk("silenced_hold", ringing, 0);
        alarm_match = 1'b0;
        step();
        alarm_match = 1'b1;
        step();
        chk("rering", ringing, 1);
        chk("rering_visible", ring_visible, 1);
        alarm_stop = 1'b1;
        step();
        chk("stop_level", ringing, 0);
        alarm_stop = 1'b0;

        // Asynchronous reset in the middle of ringing.
        alarm_match = 1'b0;
        step();
        alarm_match = 1'b1;
        pixel_x = 10'd524; pixel_y = 10'd395; video_on = 1'b1;
        step();
        chk("pre_rst_ringing", ringing, 1);
        chk("pre_rst_highlight", highlight_on, 1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_all", {cursor, sel_cmd, sel_item, highlight_on, ring_visible, ringing}, 0);
        chk("async_rst_to_ringing", ringing_t, 0);
        step();
        reset = 1'b0;
        repeat (3) step();
        chk("post_rst_no_retrigger", ringing, 0);
        alarm_match = 1'b0;
        step();
        alarm_match = 1'b1;
        step();
        chk("post_rst_new_edge", ringing, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
